// File: rtl/gcd_operand_packer.sv
// Front end of gcd_coprocessor: pairs consecutive words of a serial stream into
// (A, B) operand pairs, padding B with zero when a burst ends on an odd word.
module gcd_operand_packer #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [W-1:0]     in_bits,
  input  logic             in_last,
  output logic             operands_val,
  input  logic             operands_rdy,
  output logic [W-1:0]     operands_bits_A,
  output logic [W-1:0]     operands_bits_B,
  output logic             pair_padded,
  output logic [CNT_W-1:0] pair_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    GET_A = 2'd0,
    GET_B = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             padded_q, padded_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_fire;
  logic             out_fire;

  // Handshake signals are decoded from state only; reset masks in_rdy so no
  // word can be taken on the very edge that clears the packer.
  always_comb begin
    in_rdy       = !reset && ((state_q == GET_A) || (state_q == GET_B));
    operands_val = (state_q == SEND);
    busy         = (state_q != GET_A);
    in_fire      = in_val && in_rdy;
    out_fire     = operands_val && operands_rdy;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    padded_d = padded_q;
    count_d  = count_q;
    case (state_q)
      GET_A: begin
        if (in_fire) begin
          a_d = in_bits;
          if (in_last) begin
            b_d      = '0;
            padded_d = 1'b1;
            state_d  = SEND;
          end else begin
            state_d = GET_B;
          end
        end
      end
      GET_B: begin
        // The pair is complete here regardless of in_last.
        if (in_fire) begin
          b_d      = in_bits;
          padded_d = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_fire) begin
          count_d = count_q + CNT_W'(1);
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= GET_A;
      a_q      <= '0;
      b_q      <= '0;
      padded_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      padded_q <= padded_d;
      count_q  <= count_d;
    end
  end

  assign operands_bits_A = a_q;
  assign operands_bits_B = b_q;
  assign pair_padded     = padded_q;
  assign pair_count      = count_q;

endmodule

// File: tb/tb_gcd_operand_packer.sv
// Self-checking bench for gcd_operand_packer: directed scenarios plus a random
// stream, with expected pairs derived from the word list by a pairing model.
module tb_gcd_operand_packer;

  localparam int W     = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_val;
  logic             in_rdy;
  logic [W-1:0]     in_bits;
  logic             in_last;
  logic             operands_val;
  logic             operands_rdy;
  logic [W-1:0]     operands_bits_A;
  logic [W-1:0]     operands_bits_B;
  logic             pair_padded;
  logic [CNT_W-1:0] pair_count;
  logic             busy;

  always #5 clk = ~clk;

  gcd_operand_packer #(.W(W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_val          (in_val),
    .in_rdy          (in_rdy),
    .in_bits         (in_bits),
    .in_last         (in_last),
    .operands_val    (operands_val),
    .operands_rdy    (operands_rdy),
    .operands_bits_A (operands_bits_A),
    .operands_bits_B (operands_bits_B),
    .pair_padded     (pair_padded),
    .pair_count      (pair_count),
    .busy            (busy)
  );

  typedef struct packed {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             pad;
    logic [CNT_W-1:0] cnt;
  } pair_t;

  pair_t            obs_q[$];
  pair_t            exp_q[$];
  logic [W-1:0]     word_q[$];
  logic             last_q[$];
  int               errors = 0;
  int               checks = 0;
  int               timeouts = 0;
  int               viol_rdy = 0;
  int               viol_stable = 0;
  logic [CNT_W-1:0] exp_count;

  logic             hold_v = 1'b0;
  logic [W-1:0]     hold_a, hold_b;
  logic             hold_p;

  // Passive monitor: records every pair handed off and counts protocol breaks
  // (in_rdy high during SEND, operands changing while stalled).
  always @(negedge clk) begin
    if (reset) begin
      hold_v <= 1'b0;
    end else begin
      if (operands_val && in_rdy) viol_rdy <= viol_rdy + 1;
      if (hold_v && operands_val &&
          (operands_bits_A !== hold_a || operands_bits_B !== hold_b || pair_padded !== hold_p))
        viol_stable <= viol_stable + 1;
      if (operands_val && operands_rdy)
        obs_q.push_back('{a: operands_bits_A, b: operands_bits_B, pad: pair_padded, cnt: pair_count});
      hold_v <= operands_val && !operands_rdy;
      hold_a <= operands_bits_A;
      hold_b <= operands_bits_B;
      hold_p <= pair_padded;
    end
  end

  // Reference model: walk the word list, pairing words and padding lone finals.
  function automatic logic [CNT_W-1:0] build_expected(input logic [CNT_W-1:0] base);
    logic             have_a;
    logic [W-1:0]     a;
    logic [CNT_W-1:0] c;
    pair_t            p;
    have_a = 1'b0;
    a      = '0;
    c      = base;
    exp_q.delete();
    foreach (word_q[i]) begin
      if (!have_a) begin
        if (last_q[i]) begin
          p = '{a: word_q[i], b: '0, pad: 1'b1, cnt: c};
          exp_q.push_back(p);
          c = c + 1'b1;
        end else begin
          a      = word_q[i];
          have_a = 1'b1;
        end
      end else begin
        p = '{a: a, b: word_q[i], pad: 1'b0, cnt: c};
        exp_q.push_back(p);
        c      = c + 1'b1;
        have_a = 1'b0;
      end
    end
    return c;
  endfunction

  // Must be called just after a rising edge; returns just after the transfer edge.
  task automatic push_word(input logic [W-1:0] w, input logic last);
    int n;
    n       = 0;
    in_val  = 1'b1;
    in_bits = w;
    in_last = last;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 50) begin
        timeouts++;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_all();
    foreach (word_q[i]) push_word(word_q[i], last_q[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || operands_val) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeouts++;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    in_val       = 1'b0;
    in_bits      = '0;
    in_last      = 1'b0;
    operands_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0 || operands_val !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: in_rdy=%b val=%b busy=%b, required 0 0 0", in_rdy, operands_val, busy);
    end
    checks++;
    if (operands_bits_A !== '0 || operands_bits_B !== '0 || pair_padded !== 1'b0 || pair_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: A=%0d B=%0d pad=%b cnt=%0d, required all 0",
               operands_bits_A, operands_bits_B, pair_padded, pair_count);
    end
    reset = 1'b0;
    exp_count = '0;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: in_rdy=%b busy=%b, required 1 0", in_rdy, busy);
    end
  endtask

  task automatic test_basic();
    logic [CNT_W-1:0] nxt;
    @(posedge clk);
    #1;
    obs_q.delete();
    operands_rdy = 1'b1;
    in_val  = 1'b1;
    in_bits = 16'd12;
    in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_rdy_a: in_rdy=%b, required 1", in_rdy);
    end
    @(posedge clk);
    #1;
    in_bits = 16'd8;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || operands_val !== 1'b0 || in_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_get_b: busy=%b val=%b in_rdy=%b, required 1 0 1", busy, operands_val, in_rdy);
    end
    @(posedge clk);
    #1;
    in_val = 1'b0;
    @(negedge clk);
    checks++;
    if (operands_val !== 1'b1 || in_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_send: val=%b in_rdy=%b, required 1 0", operands_val, in_rdy);
    end
    checks++;
    if (operands_bits_A !== 16'd12 || operands_bits_B !== 16'd8 || pair_padded !== 1'b0 || pair_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL basic_pair: A=%0d B=%0d pad=%b cnt=%0d, required 12 8 0 %0d",
               operands_bits_A, operands_bits_B, pair_padded, pair_count, exp_count);
    end
    @(posedge clk);
    #1;
    nxt = exp_count + 1'b1;
    @(negedge clk);
    checks++;
    if (operands_val !== 1'b0 || busy !== 1'b0 || pair_count !== nxt) begin
      errors++;
      $display("[TB] FAIL basic_after: val=%b busy=%b cnt=%0d, required 0 0 %0d", operands_val, busy, pair_count, nxt);
    end
    exp_count = nxt;
    checks++;
    if (obs_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL basic_obs_count: got %0d pairs, required 1", obs_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    @(posedge clk);
    #1;
    obs_q.delete();
    v0 = viol_rdy + viol_stable;
    operands_rdy = 1'b1;
    word_q = '{16'd200, 16'd35, 16'd99, 16'd36};
    last_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_count = build_expected(exp_count);
    send_all();
    wait_idle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d pairs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL b2b_pair%0d: got (%0d,%0d,pad=%b,cnt=%0d), required (%0d,%0d,pad=%b,cnt=%0d)", i,
                 obs_q[i].a, obs_q[i].b, obs_q[i].pad, obs_q[i].cnt, exp_q[i].a, exp_q[i].b, exp_q[i].pad, exp_q[i].cnt);
      end
    end
    checks++;
    if (pair_count !== exp_count || (viol_rdy + viol_stable) !== v0) begin
      errors++;
      $display("[TB] FAIL b2b_end: cnt=%0d violations=%0d, required cnt=%0d violations=0",
               pair_count, viol_rdy + viol_stable - v0, exp_count);
    end
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] nxt;
    @(posedge clk);
    #1;
    obs_q.delete();
    operands_rdy = 1'b1;
    push_word(16'd15, 1'b0);
    operands_rdy = 1'b0;
    push_word(16'd9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (operands_val !== 1'b1 || in_rdy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_ctrl%0d: val=%b in_rdy=%b, required 1 0", i, operands_val, in_rdy);
      end
      checks++;
      if (operands_bits_A !== 16'd15 || operands_bits_B !== 16'd9 || pair_padded !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_data%0d: A=%0d B=%0d pad=%b, required 15 9 0",
                 i, operands_bits_A, operands_bits_B, pair_padded);
      end
      @(posedge clk);
    end
    #1;
    operands_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (operands_val !== 1'b1 || pair_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL stall_release: val=%b cnt=%0d, required 1 %0d", operands_val, pair_count, exp_count);
    end
    @(posedge clk);
    #1;
    nxt = exp_count + 1'b1;
    @(negedge clk);
    checks++;
    if (operands_val !== 1'b0 || pair_count !== nxt || obs_q.size() !== 1) begin
      errors++;
      $display("[TB] FAIL stall_done: val=%b cnt=%0d pairs=%0d, required 0 %0d 1",
               operands_val, pair_count, obs_q.size(), nxt);
    end
    exp_count = nxt;
  endtask

  task automatic test_padded();
    logic [CNT_W-1:0] base;
    @(posedge clk);
    #1;
    obs_q.delete();
    operands_rdy = 1'b1;
    word_q = '{16'd7, 16'd144, 16'd168};
    last_q = '{1'b1, 1'b0, 1'b0};
    base = exp_count;
    exp_count = build_expected(base);
    push_word(16'd7, 1'b1);
    @(negedge clk);
    checks++;
    if (operands_val !== 1'b1 || operands_bits_A !== 16'd7 || operands_bits_B !== 16'd0 || pair_padded !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pad_pair: val=%b A=%0d B=%0d pad=%b, required 1 7 0 1",
               operands_val, operands_bits_A, operands_bits_B, pair_padded);
    end
    @(posedge clk);
    #1;
    push_word(16'd144, 1'b0);
    push_word(16'd168, 1'b0);
    wait_idle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL pad_count: got %0d pairs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL pad_pair%0d: got (%0d,%0d,pad=%b,cnt=%0d), required (%0d,%0d,pad=%b,cnt=%0d)", i,
                 obs_q[i].a, obs_q[i].b, obs_q[i].pad, obs_q[i].cnt, exp_q[i].a, exp_q[i].b, exp_q[i].pad, exp_q[i].cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    operands_rdy = 1'b1;
    push_word(16'd1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_rdy: in_rdy=%b, required 0", in_rdy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    word_q = '{16'd144, 16'd168};
    last_q = '{1'b0, 1'b0};
    exp_count = build_expected('0);
    send_all();
    wait_idle();
    checks++;
    if (obs_q.size() !== 1 || obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL rst_mid_count: got %0d pairs, required 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL rst_mid_pair: got (%0d,%0d,cnt=%0d), required (144,168,cnt=0)",
                 obs_q[0].a, obs_q[0].b, obs_q[0].cnt);
      end
    end
    checks++;
    if (pair_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL rst_mid_cnt: cnt=%0d, required %0d", pair_count, exp_count);
    end
  endtask

  // Random words (including zeros), random in_last, gaps and random backpressure.
  task automatic test_random_stream(input int n_words);
    int   v0;
    int   idle;
    logic have_a;
    bit   done;
    @(posedge clk);
    #1;
    obs_q.delete();
    v0 = viol_rdy + viol_stable;
    word_q.delete();
    last_q.delete();
    have_a = 1'b0;
    for (int i = 0; i < n_words; i++) begin
      word_q.push_back(($urandom_range(0, 7) == 0) ? '0 : W'($urandom));
      last_q.push_back($urandom_range(0, 3) == 0);
      if (!have_a) have_a = !last_q[i];
      else have_a = 1'b0;
    end
    if (have_a) begin
      word_q.push_back(W'($urandom));
      last_q.push_back(1'b0);
    end
    exp_count = build_expected(exp_count);
    done = 1'b0;
    fork
      begin
        foreach (word_q[i]) begin
          idle = $urandom_range(0, 2);
          repeat (idle) begin
            @(posedge clk);
            #1;
          end
          push_word(word_q[i], last_q[i]);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          operands_rdy = ($urandom_range(0, 2) != 0);
        end
        operands_rdy = 1'b1;
      end
    join
    wait_idle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d pairs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_pair%0d: got (%0d,%0d,pad=%b,cnt=%0d), required (%0d,%0d,pad=%b,cnt=%0d)", i,
                 obs_q[i].a, obs_q[i].b, obs_q[i].pad, obs_q[i].cnt, exp_q[i].a, exp_q[i].b, exp_q[i].pad, exp_q[i].cnt);
      end
    end
    checks++;
    if (pair_count !== exp_count || (viol_rdy + viol_stable) !== v0) begin
      errors++;
      $display("[TB] FAIL rand_end: cnt=%0d violations=%0d, required cnt=%0d violations=0",
               pair_count, viol_rdy + viol_stable - v0, exp_count);
    end
  endtask

  // Issue enough pairs to roll the counter past its maximum back to zero.
  task automatic test_count_wrap();
    int n_pairs;
    @(posedge clk);
    #1;
    obs_q.delete();
    operands_rdy = 1'b1;
    n_pairs = (1 << CNT_W) - int'(exp_count);
    word_q.delete();
    last_q.delete();
    for (int i = 0; i < 2 * n_pairs; i++) begin
      word_q.push_back(W'($urandom));
      last_q.push_back(1'b0);
    end
    exp_count = build_expected(exp_count);
    send_all();
    wait_idle();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %0d pairs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL wrap_pair%0d: got (%0d,%0d,cnt=%0d), required (%0d,%0d,cnt=%0d)", i,
                 obs_q[i].a, obs_q[i].b, obs_q[i].cnt, exp_q[i].a, exp_q[i].b, exp_q[i].cnt);
      end
    end
    checks++;
    if (pair_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL wrap_cnt: cnt=%0d, required %0d", pair_count, exp_count);
    end
  endtask

  task automatic test_timeouts();
    checks++;
    if (timeouts !== 0) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: %0d waits expired, required 0", timeouts);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_padded();
    test_reset_mid();
    test_random_stream(24);
    test_random_stream(31);
    test_count_wrap();
    test_timeouts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/gcd_operand_packer.md
Name: gcd_operand_packer

Overview:
- Upstream front end of gcd_coprocessor.
- Takes a single serial stream of W-bit words, one per val/rdy handshake, and pairs consecutive words into (A, B) operand pairs.
- Presents each pair on the coprocessor's operand interface (operands_val / operands_rdy / operands_bits_A / operands_bits_B).
- Also keeps a running count of issued pairs and flags pairs that were padded because the stream ended on an odd word.

Parameters:
- W, 16, operand/word width; must match the gcd_coprocessor width parameter.
- CNT_W, 16, width of the issued-pair counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_val  input  1  upstream word valid
- in_rdy  output  1  packer can accept a word this cycle
- in_bits  input  W  upstream word
- in_last  input  1  qualifies in_bits as the final word of a burst
- operands_val  output  1  operand pair valid, drives gcd_coprocessor
- operands_rdy  input  1  gcd_coprocessor can accept a pair
- operands_bits_A  output  W  operand A, the first word of the pair
- operands_bits_B  output  W  operand B, the second word of the pair or 0 when padded
- pair_padded  output  1  current pair was padded (B forced to 0); valid while operands_val=1
- pair_count  output  CNT_W  number of pairs handed off since reset
- busy  output  1  state is not GET_A

Behaviour:
- Sampling: all state changes on the rising edge of clk; reset is sampled on that same edge.
- Reset value of every output: in_rdy=0 during the reset cycle, then 1 in GET_A; operands_val=0; operands_bits_A=0; operands_bits_B=0; pair_padded=0; pair_count=0; busy=0. State after reset is GET_A.
- Input handshake: a word transfers when in_val && in_rdy at the clock edge. in_rdy=1 only in GET_A and GET_B; in_rdy=0 in SEND.
- Output handshake: a pair transfers when operands_val && operands_rdy at the clock edge.
- Output stability: while operands_val=1 and operands_rdy=0, operands_bits_A, operands_bits_B and pair_padded are held unchanged.
- Registered outputs: all outputs come from registers or are decoded from the state only. There is no combinational path from in_* or operands_rdy to any output.
- State GET_A:
  - On an input transfer, store in_bits in the A register.
  - If in_last=1: load B=0, set the padded flag, go to SEND.
  - Otherwise go to GET_B.
- State GET_B:
  - On an input transfer, store in_bits in the B register, clear the padded flag, go to SEND.
  - in_last is ignored in this state, because the pair is already complete.
- State SEND:
  - operands_val=1.
  - On an output transfer: pair_count increments by 1 (modulo 2^CNT_W, wraps to 0), go to GET_A.
  - The A/B registers keep their values until they are overwritten by the next input transfer.
- Latency: if A transfers at edge n and B at edge n+1, operands_val is high in the cycle after edge n+1 and the pair can transfer at edge n+2.
- Throughput: at most one pair per 3 cycles; no overlap with SEND.
- Backpressure: in_rdy stays 0 for the whole time the packer waits in SEND.
- Values: no arithmetic on data; values pass through bit-exact. Zero words are forwarded like any other value.
- Reset mid-operation: overrides everything. A partially collected pair or a pending SEND is discarded, no handshake is counted, and the next word is treated as A.
- Simultaneous events: in SEND, in_val=1 has no effect. In GET_A/GET_B, operands_rdy has no effect.

Test Plan:
- Reset, then stream 12, 8 with no in_last, operands_rdy=1 -> operands_val rises 1 cycle after the B transfer; A=12, B=8, pair_padded=0; pair_count goes 0->1 on the transfer edge. Driving gcd_coprocessor then yields result 4.
- Stream 200, 35, 99, 36 back-to-back with in_val held high -> pairs (200,35) then (99,36); in_rdy=0 during each SEND cycle; pair_count ends at 2.
- Stream 15, then hold operands_rdy=0 for 5 cycles after the B word 9 -> operands_val stays 1 with (15,9) stable, in_rdy=0 throughout; the transfer happens on the first cycle operands_rdy=1.
- Single word 7 with in_last=1 -> pair (7,0), pair_padded=1. A following 144, 168 pair has pair_padded=0.
- Accept A=1, assert reset for 1 cycle, then stream 144, 168 -> first issued pair is (144,168), not (1,144); pair_count=1 after it.
- Preload by issuing 2^CNT_W-1 pairs (or use CNT_W=4 and 15 pairs), then one more pair -> pair_count wraps to 0.
